fwd_scoreboard: RTL

- Parametrised forwarding unit for the pipelined MIPS core.
- Tracks in-flight register writes in an internal DEPTH-stage shadow pipeline (EX/MEM through WB).
- For NUM_SRC source operands of the instruction in EX, it selects the youngest matching in-flight value, falling back to the register file value.
- Flags load-use hazards with `stall` and drives the register-file write port from the oldest entry.

---
 rtl/fwd_pkg.sv | 20 ++
 rtl/fwd_src_select.sv | 42 ++++
 rtl/fwd_scoreboard.sv | 108 ++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
// Entry widths match the default DATA_W/REG_AW of fwd_scoreboard.
package fwd_pkg;

   localparam int FWD_DATA_W = 32;
   localparam int FWD_REG_AW = 5;
   localparam int FWD_SEL_RF = 0;

   typedef struct packed {
      logic                  valid;
      logic [FWD_REG_AW-1:0] rd;
      logic [FWD_DATA_W-1:0] data;
      logic                  ready;
   } fwd_entry_t;

   function automatic int sel_of_stage(input int depth, input int k);
      return depth - k;
   endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Per-source lookup: youngest matching in-flight entry or the RF value.
// Also reports a not-ready (load) hit on a used operand.
module fwd_src_select
   import fwd_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int DEPTH  = 2,
   parameter int SEL_W  = $clog2(DEPTH+1)
) (
   input  fwd_entry_t        i_entries [DEPTH],
   input  logic              i_used,
   input  logic [REG_AW-1:0] i_addr,
   input  logic [DATA_W-1:0] i_rf_data,
   output logic [DATA_W-1:0] o_op,
   output logic [SEL_W-1:0]  o_sel,
   output logic              o_hazard
);

   logic w_hit;
   logic w_ready;

   // Scan oldest to youngest so the youngest match is the last write.
   always_comb begin
      w_hit   = 1'b0;
      w_ready = 1'b1;
      o_op    = i_rf_data;
      o_sel   = SEL_W'(FWD_SEL_RF);
      for (int k = DEPTH-1; k >= 0; k--) begin
         if (i_entries[k].valid &&
             i_entries[k].rd == i_addr &&
             i_addr != '0) begin
            w_hit   = 1'b1;
            w_ready = i_entries[k].ready;
            o_op    = i_entries[k].data;
            o_sel   = SEL_W'(sel_of_stage(DEPTH, k));
         end
      end
      o_hazard = i_used & w_hit & ~w_ready;
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding unit with DEPTH-stage shadow pipeline and load-use stall.
// Define FWD_STATS_EN to add saturating fwd_count/stall_count outputs.
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   parameter int SEL_W   = $clog2(DEPTH+1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ex_valid,
   input  logic                      ex_wr_en,
   input  logic                      ex_is_load,
   input  logic [REG_AW-1:0]         ex_rd,
   input  logic [DATA_W-1:0]         ex_result,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      pipe_hold,
   input  logic                      flush,
   input  logic [NUM_SRC-1:0]        src_used,
   input  logic [NUM_SRC*REG_AW-1:0] src_addr,
   input  logic [NUM_SRC*DATA_W-1:0] src_rf_data,
   output logic [NUM_SRC*DATA_W-1:0] op_out,
   output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
   output logic                      stall,
   output logic                      wb_we,
   output logic [REG_AW-1:0]         wb_rd,
   output logic [DATA_W-1:0]         wb_data
`ifdef FWD_STATS_EN
   ,
   output logic [31:0]               fwd_count,
   output logic [31:0]               stall_count
`endif
);

   fwd_entry_t         r_entries [DEPTH];
   logic [NUM_SRC-1:0] w_haz;
   logic               w_stall;
   logic               w_cap;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_select #(
         .DATA_W (DATA_W),
         .REG_AW (REG_AW),
         .DEPTH  (DEPTH),
         .SEL_W  (SEL_W)
      ) u_sel (
         .i_entries (r_entries),
         .i_used    (src_used[i]),
         .i_addr    (src_addr[i*REG_AW +: REG_AW]),
         .i_rf_data (src_rf_data[i*DATA_W +: DATA_W]),
         .o_op      (op_out[i*DATA_W +: DATA_W]),
         .o_sel     (fwd_sel[i*SEL_W +: SEL_W]),
         .o_hazard  (w_haz[i])
      );
   end

   assign w_stall = ex_valid & (|w_haz);
   assign stall   = w_stall;
   assign w_cap   = ex_valid & ex_wr_en & (ex_rd != '0) &
                    ~flush & ~w_stall;

   // Load data lands as an entry leaves stage 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++)
            r_entries[k] <= '0;
      end else if (!pipe_hold) begin
         r_entries[0] <= '{valid: w_cap,
                           rd:    ex_rd,
                           data:  ex_result,
                           ready: ~ex_is_load};
         for (int k = 1; k < DEPTH; k++)
            r_entries[k] <= r_entries[k-1];
         if (!r_entries[0].ready) begin
            r_entries[1].data  <= mem_rdata;
            r_entries[1].ready <= 1'b1;
         end
      end
   end

   assign wb_we   = r_entries[DEPTH-1].valid;
   assign wb_rd   = r_entries[DEPTH-1].rd;
   assign wb_data = r_entries[DEPTH-1].data;

`ifdef FWD_STATS_EN
   logic [31:0] r_fwd_count;
   logic [31:0] r_stall_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fwd_count   <= '0;
         r_stall_count <= '0;
      end else if (!pipe_hold) begin
         if ((|fwd_sel) && !w_stall && r_fwd_count != '1)
            r_fwd_count <= r_fwd_count + 32'd1;
         if (w_stall && r_stall_count != '1)
            r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign fwd_count   = r_fwd_count;
   assign stall_count = r_stall_count;
`endif

endmodule
